// File: rtl/piece_ctrl.sv
// piece_ctrl: active-piece controller for the Tetris board.
// Holds the falling piece's anchor, rotation and colour. Arbitrates one
// move per cycle between player requests and gravity, runs the
// spawn / fall / lock-delay / commit sequence, and presents draw and
// erase cell sets to the board.
module piece_ctrl #(
    parameter logic [7:0] GRAVITY_TICKS = 8'd48,
    parameter logic [7:0] LOCK_TICKS    = 8'd30,
    parameter logic [4:0] SPAWN_X       = 5'd3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [2:0]  next_piece,
    input  logic        req_left,
    input  logic        req_right,
    input  logic        req_rot_l,
    input  logic        req_rot_r,
    input  logic        req_down,
    input  logic [4:0]  can_move,
    input  logic [19:0] cur_xblock,
    input  logic [19:0] cur_yblock,
    output logic [4:0]  anchor_x,
    output logic [4:0]  anchor_y,
    output logic [1:0]  rot,
    output logic [2:0]  block,
    output logic [19:0] x_block,
    output logic [19:0] y_block,
    output logic [19:0] save_xblock,
    output logic [19:0] save_yblock,
    output logic        piece_locked,
    output logic        request_next
);
    localparam logic [2:0] EMPTY     = 3'd0;
    localparam logic [7:0] GRAV_LAST = GRAVITY_TICKS - 8'd1;
    localparam logic [7:0] LOCK_LAST = LOCK_TICKS - 8'd1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SPAWN      = 3'd1,
        FALL       = 3'd2,
        LOCK_DELAY = 3'd3,
        COMMIT     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        MV_NONE  = 3'd0,
        MV_ROT_R = 3'd1,
        MV_ROT_L = 3'd2,
        MV_LEFT  = 3'd3,
        MV_RIGHT = 3'd4,
        MV_DOWN  = 3'd5
    } move_t;

    state_t      state_r, state_next_s;
    logic [4:0]  anchor_x_r, anchor_x_next_s;
    logic [4:0]  anchor_y_r, anchor_y_next_s;
    logic [1:0]  rotation_r, rotation_next_s;
    logic [2:0]  block_r, block_next_s;
    logic [7:0]  grav_cnt_r, grav_cnt_next_s;
    logic        grav_pend_r, grav_pend_next_s;
    logic [7:0]  lock_cnt_r, lock_cnt_next_s;
    logic        erase_valid_r;
    logic [19:0] prev_x_r, prev_y_r;
    logic        piece_locked_r, request_next_r;
    move_t       move_s;
    logic        accept_s;
    logic        grav_due_s;
    logic        down_want_s;

    // Select the single highest-priority action wanted this cycle and judge its legality.
    always_comb begin
        grav_due_s  = grav_pend_r | (grav_cnt_r == GRAV_LAST);
        down_want_s = (state_r == FALL) & (req_down | grav_due_s);
        move_s      = MV_NONE;
        accept_s    = 1'b0;
        if ((state_r == FALL) || (state_r == LOCK_DELAY)) begin
            if (req_rot_r) begin
                move_s   = MV_ROT_R;
                accept_s = can_move[2];
            end else if (req_rot_l) begin
                move_s   = MV_ROT_L;
                accept_s = can_move[1];
            end else if (req_left) begin
                move_s   = MV_LEFT;
                accept_s = can_move[4];
            end else if (req_right) begin
                move_s   = MV_RIGHT;
                accept_s = can_move[3];
            end else if (down_want_s) begin
                move_s   = MV_DOWN;
                accept_s = can_move[0];
            end else begin
                move_s   = MV_NONE;
                accept_s = 1'b0;
            end
        end else begin
            move_s   = MV_NONE;
            accept_s = 1'b0;
        end
    end

    // Next state, counters and pose for the coming cycle.
    always_comb begin
        state_next_s     = state_r;
        anchor_x_next_s  = anchor_x_r;
        anchor_y_next_s  = anchor_y_r;
        rotation_next_s  = rotation_r;
        block_next_s     = block_r;
        grav_cnt_next_s  = grav_cnt_r;
        grav_pend_next_s = grav_pend_r;
        lock_cnt_next_s  = lock_cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SPAWN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SPAWN: begin
                anchor_x_next_s  = SPAWN_X;
                anchor_y_next_s  = 5'd0;
                rotation_next_s  = 2'd0;
                block_next_s     = next_piece;
                grav_cnt_next_s  = 8'd0;
                grav_pend_next_s = 1'b0;
                state_next_s     = FALL;
            end
            FALL: begin
                // A tick that is not served right away stays pending.
                if (grav_cnt_r == GRAV_LAST) begin
                    grav_cnt_next_s  = 8'd0;
                    grav_pend_next_s = 1'b1;
                end else begin
                    grav_cnt_next_s  = grav_cnt_r + 8'd1;
                end
                if (accept_s && (move_s == MV_DOWN)) begin
                    grav_cnt_next_s  = 8'd0;
                    grav_pend_next_s = 1'b0;
                end else begin
                    grav_pend_next_s = grav_pend_next_s;
                end
                // Grounded: the wanted step down is consumed by the lock delay.
                if (down_want_s && !can_move[0]) begin
                    state_next_s     = LOCK_DELAY;
                    lock_cnt_next_s  = 8'd0;
                    grav_cnt_next_s  = 8'd0;
                    grav_pend_next_s = 1'b0;
                end else begin
                    state_next_s = FALL;
                end
            end
            LOCK_DELAY: begin
                if (can_move[0]) begin
                    state_next_s     = FALL;
                    grav_cnt_next_s  = 8'd0;
                    grav_pend_next_s = 1'b0;
                end else if (lock_cnt_r == LOCK_LAST) begin
                    state_next_s = COMMIT;
                end else begin
                    lock_cnt_next_s = lock_cnt_r + 8'd1;
                end
            end
            COMMIT: begin
                state_next_s = SPAWN;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (accept_s) begin
            case (move_s)
                MV_ROT_R: rotation_next_s = rotation_r + 2'd1;
                MV_ROT_L: rotation_next_s = rotation_r - 2'd1;
                MV_LEFT:  anchor_x_next_s = anchor_x_r - 5'd1;
                MV_RIGHT: anchor_x_next_s = anchor_x_r + 5'd1;
                MV_DOWN:  anchor_y_next_s = anchor_y_r + 5'd1;
                default:  rotation_next_s = rotation_r;
            endcase
        end else begin
            rotation_next_s = rotation_next_s;
        end
    end

    // State, pose, counters, erase tracking and output pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r        <= IDLE;
            anchor_x_r     <= SPAWN_X;
            anchor_y_r     <= 5'd0;
            rotation_r     <= 2'd0;
            block_r        <= EMPTY;
            grav_cnt_r     <= 8'd0;
            grav_pend_r    <= 1'b0;
            lock_cnt_r     <= 8'd0;
            erase_valid_r  <= 1'b0;
            prev_x_r       <= 20'd0;
            prev_y_r       <= 20'd0;
            piece_locked_r <= 1'b0;
            request_next_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            anchor_x_r     <= anchor_x_next_s;
            anchor_y_r     <= anchor_y_next_s;
            rotation_r     <= rotation_next_s;
            block_r        <= block_next_s;
            grav_cnt_r     <= grav_cnt_next_s;
            grav_pend_r    <= grav_pend_next_s;
            lock_cnt_r     <= lock_cnt_next_s;
            // Only an accepted move erases; SPAWN and COMMIT never accept, so a locked piece stays.
            erase_valid_r  <= accept_s;
            prev_x_r       <= cur_xblock;
            prev_y_r       <= cur_yblock;
            piece_locked_r <= (state_next_s == COMMIT);
            request_next_r <= (state_next_s == SPAWN);
        end
    end

    assign anchor_x     = anchor_x_r;
    assign anchor_y     = anchor_y_r;
    assign rot          = rotation_r;
    assign block        = block_r;
    assign x_block      = cur_xblock;
    assign y_block      = cur_yblock;
    // Erasing the current cells is harmless because the board draws after it erases.
    assign save_xblock  = erase_valid_r ? prev_x_r : cur_xblock;
    assign save_yblock  = erase_valid_r ? prev_y_r : cur_yblock;
    assign piece_locked = piece_locked_r;
    assign request_next = request_next_r;

endmodule

// File: tb/tb_piece_ctrl.sv
// tb_piece_ctrl: directed and randomized bench for piece_ctrl with a
// behavioural model of the active piece.
module tb_piece_ctrl;
    localparam int G  = 48;
    localparam int L  = 30;
    localparam int SX = 3;
    localparam int PH_IDLE = 0, PH_SPAWN = 1, PH_FALL = 2, PH_LOCK = 3, PH_COMMIT = 4;

    logic        Clk = 1'b0;
    logic        Reset, start;
    logic [2:0]  next_piece;
    logic        req_left, req_right, req_rot_l, req_rot_r, req_down;
    logic [4:0]  can_move;
    logic [19:0] cur_xblock, cur_yblock;
    logic [4:0]  anchor_x, anchor_y;
    logic [1:0]  rot;
    logic [2:0]  block;
    logic [19:0] x_block, y_block, save_xblock, save_yblock;
    logic        piece_locked, request_next;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model state
    int m_x = SX, m_y = 0, m_rot = 0, m_blk = 0, m_phase = PH_IDLE;
    int m_age = 0, m_lock_age = 0;
    bit m_erase = 1'b0, m_locked = 1'b0, m_reqnext = 1'b0;
    logic [19:0] m_prev_x = 20'd0, m_prev_y = 20'd0;

    always #5 Clk = ~Clk;

    // stand-in for the piece-geometry logic: four cells from anchor and rotation
    function automatic logic [19:0] geo_x(input int x, input int r);
        logic [19:0] v;
        v = 20'd0;
        for (int i = 0; i < 4; i++) v[i*5 +: 5] = 5'((x + ((i + r) % 4)) % 32);
        return v;
    endfunction

    function automatic logic [19:0] geo_y(input int y, input int r);
        logic [19:0] v;
        v = 20'd0;
        for (int i = 0; i < 4; i++) v[i*5 +: 5] = 5'((y + ((i * (r + 1)) % 3)) % 32);
        return v;
    endfunction

    assign cur_xblock = geo_x(int'(anchor_x), int'(rot));
    assign cur_yblock = geo_y(int'(anchor_y), int'(rot));

    piece_ctrl dut (
        .Clk(Clk), .Reset(Reset), .start(start), .next_piece(next_piece),
        .req_left(req_left), .req_right(req_right), .req_rot_l(req_rot_l),
        .req_rot_r(req_rot_r), .req_down(req_down), .can_move(can_move),
        .cur_xblock(cur_xblock), .cur_yblock(cur_yblock),
        .anchor_x(anchor_x), .anchor_y(anchor_y), .rot(rot), .block(block),
        .x_block(x_block), .y_block(y_block),
        .save_xblock(save_xblock), .save_yblock(save_yblock),
        .piece_locked(piece_locked), .request_next(request_next)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // model: advance one clock from the inputs seen at this edge
    always @(posedge Clk) begin
        int nx, ny, nr, nblk, nph, nage, nlock;
        bit moved, fell, down_wanted;
        nx = m_x; ny = m_y; nr = m_rot; nblk = m_blk; nph = m_phase;
        nage = m_age; nlock = m_lock_age; moved = 1'b0; fell = 1'b0;
        if (Reset) begin
            nx = SX; ny = 0; nr = 0; nblk = 0; nph = PH_IDLE; nage = 0; nlock = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (start) nph = PH_SPAWN;
                PH_SPAWN: begin
                    nx = SX; ny = 0; nr = 0; nblk = int'(next_piece); nage = 0; nph = PH_FALL;
                end
                PH_FALL, PH_LOCK: begin
                    down_wanted = (m_phase == PH_FALL) && (req_down || (m_age >= G - 1));
                    if (req_rot_r) begin
                        if (can_move[2]) begin nr = (m_rot + 1) % 4; moved = 1'b1; end
                    end else if (req_rot_l) begin
                        if (can_move[1]) begin nr = (m_rot + 3) % 4; moved = 1'b1; end
                    end else if (req_left) begin
                        if (can_move[4]) begin nx = (m_x + 31) % 32; moved = 1'b1; end
                    end else if (req_right) begin
                        if (can_move[3]) begin nx = (m_x + 1) % 32; moved = 1'b1; end
                    end else if (down_wanted && can_move[0]) begin
                        ny = (m_y + 1) % 32; moved = 1'b1; fell = 1'b1;
                    end
                    if (m_phase == PH_FALL) begin
                        if (down_wanted && !can_move[0]) begin
                            nph = PH_LOCK; nlock = 0; nage = 0;
                        end else if (fell) begin
                            nage = 0;
                        end else begin
                            nage = (m_age < 1000) ? m_age + 1 : m_age;
                        end
                    end else begin
                        if (can_move[0]) begin
                            nph = PH_FALL; nage = 0;
                        end else if (m_lock_age == L - 1) begin
                            nph = PH_COMMIT;
                        end else begin
                            nlock = m_lock_age + 1;
                        end
                    end
                end
                PH_COMMIT: nph = PH_SPAWN;
                default: nph = PH_IDLE;
            endcase
        end
        m_prev_x   <= geo_x(m_x, m_rot);
        m_prev_y   <= geo_y(m_y, m_rot);
        m_erase    <= moved;
        m_locked   <= (nph == PH_COMMIT);
        m_reqnext  <= (nph == PH_SPAWN);
        m_x <= nx; m_y <= ny; m_rot <= nr; m_blk <= nblk; m_phase <= nph;
        m_age <= nage; m_lock_age <= nlock;
    end

    // compare every output against the model each cycle
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("anchor_x", 32'(anchor_x), 32'(m_x));
            chk("anchor_y", 32'(anchor_y), 32'(m_y));
            chk("rot", 32'(rot), 32'(m_rot));
            chk("block", 32'(block), 32'(m_blk));
            chk("piece_locked", 32'(piece_locked), 32'(m_locked));
            chk("request_next", 32'(request_next), 32'(m_reqnext));
            chk("x_block", 32'(x_block), 32'(geo_x(m_x, m_rot)));
            chk("y_block", 32'(y_block), 32'(geo_y(m_y, m_rot)));
            chk("save_xblock", 32'(save_xblock), 32'(m_erase ? m_prev_x : geo_x(m_x, m_rot)));
            chk("save_yblock", 32'(save_yblock), 32'(m_erase ? m_prev_y : geo_y(m_y, m_rot)));
        end
    end

    task automatic wait_y_change(output int n);
        logic [4:0] y0;
        y0 = anchor_y;
        n = 0;
        do begin
            tick();
            n++;
        end while ((anchor_y == y0) && (n < 200));
    endtask

    initial begin
        int n, pulses, p0;
        Reset = 1'b1; start = 1'b0; next_piece = 3'd0;
        req_left = 1'b0; req_right = 1'b0; req_rot_l = 1'b0; req_rot_r = 1'b0; req_down = 1'b0;
        can_move = 5'b11111;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_anchor_x", 32'(anchor_x), 32'd3);
        chk("rst_anchor_y", 32'(anchor_y), 32'd0);
        chk("rst_rot", 32'(rot), 32'd0);
        chk("rst_block", 32'(block), 32'd0);
        chk("rst_locked", 32'(piece_locked), 32'd0);
        chk("rst_req_next", 32'(request_next), 32'd0);

        // start: one SPAWN cycle, then the new piece
        Reset = 1'b0; next_piece = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("spawn_req_next", 32'(request_next), 32'd1);
        tick();
        next_piece = 3'd2;
        chk("spawn_anchor_x", 32'(anchor_x), 32'd3);
        chk("spawn_anchor_y", 32'(anchor_y), 32'd0);
        chk("spawn_rot", 32'(rot), 32'd0);
        chk("spawn_block", 32'(block), 32'd5);
        chk("spawn_req_clr", 32'(request_next), 32'd0);
        chk("spawn_save_x", 32'(save_xblock), 32'h31483);

        // legal left, then its one-cycle erase
        req_left = 1'b1; tick(); req_left = 1'b0;
        chk("left_x", 32'(anchor_x), 32'd2);
        chk("left_save_old", 32'(save_xblock), 32'h31483);
        chk("left_draw_new", 32'(x_block), 32'h29062);
        tick();
        chk("left_save_after", 32'(save_xblock), 32'h29062);

        // illegal left
        can_move = 5'b01111; req_left = 1'b1; tick(); req_left = 1'b0; can_move = 5'b11111;
        chk("left_blocked_x", 32'(anchor_x), 32'd2);
        chk("left_blocked_save", 32'(save_xblock), 32'h29062);

        // rotate right beats left; rotate left wraps
        req_rot_r = 1'b1; req_left = 1'b1; tick(); req_rot_r = 1'b0; req_left = 1'b0;
        chk("prio_rot", 32'(rot), 32'd1);
        chk("prio_x", 32'(anchor_x), 32'd2);
        req_rot_l = 1'b1; tick();
        chk("rot_l_1to0", 32'(rot), 32'd0);
        tick(); req_rot_l = 1'b0;
        chk("rot_l_wrap", 32'(rot), 32'd3);

        // gravity: first step at FALL cycle 48, then every 48 cycles
        wait_y_change(n);
        chk("grav_first", 32'(n), 32'd42);
        wait_y_change(n);
        chk("grav_period", 32'(n), 32'd48);
        for (int i = 0; i < 20; i++) tick();
        req_down = 1'b1; tick(); req_down = 1'b0;
        chk("down_y", 32'(anchor_y), 32'd3);
        wait_y_change(n);
        chk("grav_restart", 32'(n), 32'd48);

        // grounded at a gravity tick: 47 fall + 1 + 30 lock cycles, then commit
        can_move = 5'b11110;
        n = 0;
        do begin tick(); n++; end while ((piece_locked !== 1'b1) && (n < 300));
        chk("lock_latency", 32'(n), 32'd78);
        tick();
        chk("lock_pulse_once", 32'(piece_locked), 32'd0);
        chk("lock_then_spawn", 32'(request_next), 32'd1);
        tick();
        chk("respawn_x", 32'(anchor_x), 32'd3);
        chk("respawn_y", 32'(anchor_y), 32'd0);

        // lock delay aborted at lock cycle 10
        pulses = 0;
        for (int i = 0; i < 58; i++) begin tick(); if (piece_locked === 1'b1) pulses++; end
        can_move = 5'b11111;
        for (int i = 0; i < 60; i++) begin tick(); if (piece_locked === 1'b1) pulses++; end
        chk("abort_no_lock", 32'(pulses), 32'd0);
        chk("abort_fell", 32'(anchor_y), 32'd1);

        // reset during lock delay
        can_move = 5'b11110;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (piece_locked === 1'b1) pulses++; end
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("mid_rst_x", 32'(anchor_x), 32'd3);
        chk("mid_rst_y", 32'(anchor_y), 32'd0);
        chk("mid_rst_rot", 32'(rot), 32'd0);
        chk("mid_rst_block", 32'(block), 32'd0);
        chk("mid_rst_locked", 32'(piece_locked), 32'd0);
        for (int i = 0; i < 40; i++) begin tick(); if (piece_locked === 1'b1) pulses++; end
        chk("mid_rst_no_lock", 32'(pulses), 32'd0);

        // randomized traffic
        for (int seg = 0; seg < 12; seg++) begin
            p0 = (seg % 4 == 0) ? 100 : (seg % 4 == 1) ? 70 : (seg % 4 == 2) ? 4 : 0;
            for (int c = 0; c < 300; c++) begin
                Reset      = ($urandom_range(0, 699) == 0);
                start      = ($urandom_range(0, 9) == 0);
                req_left   = ($urandom_range(0, 5) == 0);
                req_right  = ($urandom_range(0, 5) == 0);
                req_rot_l  = ($urandom_range(0, 5) == 0);
                req_rot_r  = ($urandom_range(0, 5) == 0);
                req_down   = ($urandom_range(0, 5) == 0);
                next_piece = 3'($urandom_range(1, 7));
                can_move[4:1] = 4'($urandom_range(0, 15));
                can_move[0]   = ($urandom_range(0, 99) < p0);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piece_ctrl.md
# piece_ctrl

Active-piece controller for the Tetris board. It holds the falling piece's anchor (x, y) and rotation, and accepts one movement request per cycle from player input and a gravity timer. It runs a spawn / fall / lock-delay / commit state machine and drives the board's draw and erase buses so that each accepted move erases the old cells and draws the new ones. It sits between the input decoder, the external piece-geometry logic (which turns anchor and rotation into cell coordinates and candidate moves) and `board`.

## Interface
Parameters:
- `GRAVITY_TICKS`, default 8'd48: Clk cycles between gravity steps (Clk is the 60 Hz game clock).
- `LOCK_TICKS`, default 8'd30: Clk cycles a grounded piece waits before it locks.
- `SPAWN_X`, default 5'd3: anchor x loaded on spawn. Anchor y on spawn is always 0.

Ports:
- `Clk`  in  1  game clock, single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; starts the game from IDLE.
- `next_piece`  in  block_color  colour/type of the next piece, sampled in SPAWN.
- `req_left`, `req_right`, `req_rot_l`, `req_rot_r`, `req_down`  in  1 each  one-cycle request pulses.
- `can_move`  in  5  legality of each candidate move for the current pose, from `board`: [4] left, [3] right, [2] rotate right, [1] rotate left, [0] down.
- `cur_xblock`, `cur_yblock`  in  20 each  four 5-bit cell coordinates of the current pose, from the geometry logic.
- `anchor_x`, `anchor_y`  out  5 each  current anchor.
- `rot`  out  2  current rotation, 0 to 3.
- `block`  out  block_color  colour to draw.
- `x_block`, `y_block`  out  20 each  cells to draw; equal to `cur_xblock` and `cur_yblock`.
- `save_xblock`, `save_yblock`  out  20 each  cells to erase.
- `piece_locked`  out  1  one-cycle pulse when a piece commits.
- `request_next`  out  1  one-cycle pulse in SPAWN; tells the upstream generator to advance `next_piece`.

## Operation
States: IDLE, SPAWN, FALL, LOCK_DELAY, COMMIT.

Reset:
- state = IDLE, anchor = (SPAWN_X, 0), `rot` = 0, `block` = EMPTY.
- Both counters = 0, `erase_valid` = 0, `piece_locked` = 0, `request_next` = 0.

State transitions:
- IDLE: on `start`, go to SPAWN. All requests are ignored.
- SPAWN (one cycle):
  - Load anchor (SPAWN_X, 0) and `rot` = 0.
  - Set `block` = `next_piece` and pulse `request_next`.
  - Clear the gravity counter and `erase_valid`.
  - Go to FALL.
- FALL:
  - The gravity counter increments every cycle.
  - When the counter reaches GRAVITY_TICKS-1, a gravity tick is raised. It stays pending until served.
- Action arbitration (FALL and LOCK_DELAY): at most one action is accepted per cycle. Priority is `req_rot_r` > `req_rot_l` > `req_left` > `req_right` > down.
  - Down means `req_down` OR a pending gravity tick.
  - An action is accepted only if its `can_move` bit is 1.
  - A rejected or lower-priority player request is dropped.
  - A pending gravity tick is kept.
- Effect of an accepted action:
  - Left: x-1. Right: x+1. Rotate right: `rot`+1 mod 4. Rotate left: `rot`-1 mod 4. Down: y+1.
  - An accepted down clears the gravity counter and the pending tick.
- Entering LOCK_DELAY: in FALL, when a down is wanted (request or pending tick) and `can_move[0]` = 0, go to LOCK_DELAY with the lock counter = 0.
- LOCK_DELAY:
  - The lock counter increments every cycle. Left, right and rotate are still arbitrated.
  - If `can_move[0]` = 1 at any cycle, return to FALL with the gravity counter cleared.
  - If the counter reaches LOCK_TICKS-1 and `can_move[0]` = 0, go to COMMIT.
- COMMIT (one cycle): pulse `piece_locked`, clear `erase_valid`, go to SPAWN. The piece's cells remain drawn.

Erase tracking:
- Each cycle, the previous cycle's `cur_xblock`/`cur_yblock` are registered as the previous pose.
- `erase_valid` = 1 for exactly the cycle after an accepted action. In that cycle `save_*` = previous pose.
- Otherwise `save_*` = `cur_*`. This is idempotent, because `board` applies the draw after the erase.
- `erase_valid` is forced to 0 in the cycle after SPAWN, so the locked piece is never erased.

## Timing
- Request pulse at edge N is accepted against the `can_move` value in cycle N. Anchor and `rot` update at edge N+1.
- Cycle N+1:
  - `cur_*` and `can_move` reflect the new pose (geometry and `board` are combinational).
  - `save_*` = old cells, `erase_valid` = 1.
  - `board` erases and redraws at edge N+2.
- Gravity: with no input, y increments once every GRAVITY_TICKS cycles.
- Lock latency: LOCK_TICKS cycles in LOCK_DELAY, then 1 cycle COMMIT, then 1 cycle SPAWN.
- `Reset` asserted mid-game, in any state: the next cycle is IDLE with all reset values. No commit pulse is produced.
- `start` outside IDLE is ignored.

## Test plan
- Reset, then `start`: SPAWN lasts 1 cycle with `request_next` = 1. Then anchor = (3, 0), `rot` = 0 and `block` = `next_piece`. `save_*` = `cur_*`.
- `req_left` with `can_move[4]` = 1: anchor_x goes 3 to 2 one cycle later. `save_*` = the old cells for exactly one cycle. Repeat with `can_move[4]` = 0: no change and `erase_valid` stays 0.
- `req_rot_r` and `req_left` in the same cycle, both legal: `rot` goes 0 to 1 and anchor_x is unchanged. `req_rot_l` from `rot` = 0 gives `rot` = 3.
- No input, all moves legal: anchor_y increments exactly every 48 cycles. A `req_down` at cycle 20 gives y+1 and restarts the 48-cycle count.
- Force `can_move[0]` = 0 at a gravity tick: LOCK_DELAY for 30 cycles, then `piece_locked` pulses once, then SPAWN. Raising `can_move[0]` at cycle 10 of LOCK_DELAY returns to FALL instead, with no lock.
- Assert `Reset` during LOCK_DELAY: the next cycle is IDLE, anchor = (3, 0), `block` = EMPTY, and no `piece_locked` pulse.
